// File: rtl/wb_write_queue_pkg.sv
// Shared types and constants for the register-file write queue.
// Entries pair a destination register index with its result value.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup over the queued writes.
// Scans from oldest to newest so the youngest matching entry wins.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [REG_ADDR_W-1:0]        lookup_addr,
  output logic                         hit,
  output logic [REG_DATA_W-1:0]        hit_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // Offset k from the head is k-th oldest; later hits overwrite earlier ones.
      idx = rd_ptr + PTR_W'(k);
      if (valid[idx] && (entries[idx].addr == lookup_addr) &&
          (lookup_addr != REG_ZERO)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write queue between execute/memory results and the register file,
// with Rs/Rt forwarding of queued values to decode.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [ADDR_W-1:0]          res_addr,
  input  logic [DATA_W-1:0]          res_data,
  output logic [ADDR_W-1:0]          Rd_addr,
  output logic [DATA_W-1:0]          Rd_data,
  output logic                       RegWrite,
  input  logic [ADDR_W-1:0]          Rs_addr,
  input  logic [ADDR_W-1:0]          Rt_addr,
  output logic                       Rs_fwd,
  output logic [DATA_W-1:0]          Rs_fwd_data,
  output logic                       Rt_fwd,
  output logic [DATA_W-1:0]          Rt_fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   age [DEPTH];
  logic [DEPTH-1:0]   valid_mask;
  logic               accept;
  logic               push;
  logic               pop;

  // Handshake: a result transfers at a rising edge when res_valid && res_ready.
  // res_ready is a function of occupancy only, so a full queue stalls even
  // when the head drains in the same cycle. Register 0 transfers but is dropped.
  assign res_ready = (count_q < CNT_W'(DEPTH));
  assign accept    = res_valid && res_ready;
  assign push      = accept && (res_addr != REG_ZERO);
  assign pop       = (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].addr <= res_addr;
      mem[wr_ptr].data <= res_data;
    end
  end

  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i]        = PTR_W'(i) - rd_ptr;
      valid_mask[i] = ({1'b0, age[i]} < count_q);
    end
  end

  assign RegWrite = pop;
  assign Rd_addr  = pop ? mem[rd_ptr].addr : '0;
  assign Rd_data  = pop ? mem[rd_ptr].data : '0;
  assign count    = count_q;

  wb_fwd_match #(.DEPTH(DEPTH)) u_rs_match (
    .entries     (mem),
    .valid       (valid_mask),
    .rd_ptr      (rd_ptr),
    .lookup_addr (Rs_addr),
    .hit         (Rs_fwd),
    .hit_data    (Rs_fwd_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_rt_match (
    .entries     (mem),
    .valid       (valid_mask),
    .rd_ptr      (rd_ptr),
    .lookup_addr (Rt_addr),
    .hit         (Rt_fwd),
    .hit_data    (Rt_fwd_data)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and random stimulus for wb_write_queue, checked against a queue
// model of the entries that should currently be held.
module tb_wb_write_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = REG_ADDR_W + REG_DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    res_valid;
  logic                    res_ready;
  logic [REG_ADDR_W-1:0]   res_addr;
  logic [REG_DATA_W-1:0]   res_data;
  logic [REG_ADDR_W-1:0]   Rd_addr;
  logic [REG_DATA_W-1:0]   Rd_data;
  logic                    RegWrite;
  logic [REG_ADDR_W-1:0]   Rs_addr;
  logic [REG_ADDR_W-1:0]   Rt_addr;
  logic                    Rs_fwd;
  logic [REG_DATA_W-1:0]   Rs_fwd_data;
  logic                    Rt_fwd;
  logic [REG_DATA_W-1:0]   Rt_fwd_data;
  logic [$clog2(DEPTH):0]  count;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .Rd_addr     (Rd_addr),
    .Rd_data     (Rd_data),
    .RegWrite    (RegWrite),
    .Rs_addr     (Rs_addr),
    .Rt_addr     (Rt_addr),
    .Rs_fwd      (Rs_fwd),
    .Rs_fwd_data (Rs_fwd_data),
    .Rt_fwd      (Rt_fwd),
    .Rt_fwd_data (Rt_fwd_data),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fwd_model(input logic [REG_ADDR_W-1:0] a, output logic hit,
                           output logic [REG_DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (exp_q[i]) begin
      if (a != REG_ZERO && exp_q[i][EW-1:REG_DATA_W] == a) begin
        hit = 1'b1;
        d   = exp_q[i][REG_DATA_W-1:0];
      end
    end
  endtask

  // scoreboard: head of exp_q must be on the write port whenever anything is queued
  task automatic check_outputs();
    logic [EW-1:0]         head;
    logic                  hs, ht;
    logic [REG_DATA_W-1:0] ds, dt;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("count",     count,     exp_q.size());
    chk("res_ready", res_ready, exp_q.size() < DEPTH);
    chk("RegWrite",  RegWrite,  exp_q.size() != 0);
    chk("Rd_addr",   Rd_addr,   head[EW-1:REG_DATA_W]);
    chk("Rd_data",   Rd_data,   head[REG_DATA_W-1:0]);
    fwd_model(Rs_addr, hs, ds);
    fwd_model(Rt_addr, ht, dt);
    chk("Rs_fwd",      Rs_fwd,      hs);
    chk("Rs_fwd_data", Rs_fwd_data, ds);
    chk("Rt_fwd",      Rt_fwd,      ht);
    chk("Rt_fwd_data", Rt_fwd_data, dt);
  endtask

  // driver: one clock cycle, entered and left at a falling edge
  task automatic cycle(input logic v, input logic [REG_ADDR_W-1:0] a,
                       input logic [REG_DATA_W-1:0] d);
    bit acc;
    res_valid = v;
    res_addr  = a;
    res_data  = d;
    #1;
    check_outputs();
    acc = v && (exp_q.size() < DEPTH);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc && a != REG_ZERO) exp_q.push_back({a, d});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  initial begin
    rst       = 1'b1;
    res_valid = 1'b0;
    res_addr  = '0;
    res_data  = '0;
    Rs_addr   = '0;
    Rt_addr   = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // single write with Rs lookup
    Rs_addr = 5'd3;
    Rt_addr = 5'd4;
    cycle(1'b1, 5'd3, 32'h0000_00AA);
    idle(2);

    // back-to-back pushes while draining
    Rs_addr = 5'd2;
    Rt_addr = 5'd5;
    for (int i = 1; i <= 5; i++) cycle(1'b1, REG_ADDR_W'(i), 32'h100 + 32'(i));
    idle(2);

    // register 0 is dropped
    Rs_addr = 5'd0;
    Rt_addr = 5'd0;
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF);
    idle(2);

    // same register, youngest wins
    Rt_addr = 5'd7;
    cycle(1'b1, 5'd7, 32'h11);
    cycle(1'b1, 5'd7, 32'h22);
    cycle(1'b1, 5'd7, 32'h33);
    idle(2);

    // push/pop overlap
    Rs_addr = 5'd9;
    cycle(1'b1, 5'd8, 32'h808);
    cycle(1'b1, 5'd9, 32'h909);
    cycle(1'b1, 5'd10, 32'hA0A);
    idle(1);

    // async reset while an entry is on the write port
    cycle(1'b1, 5'd12, 32'hC0C);
    #2 rst = 1'b1;
    #1;
    chk("rst_count",     count,     0);
    chk("rst_RegWrite",  RegWrite,  0);
    chk("rst_Rd_addr",   Rd_addr,   0);
    chk("rst_Rd_data",   Rd_data,   0);
    chk("rst_res_ready", res_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    Rs_addr = 5'd12;
    idle(3);

    // random traffic over a narrow address range to force matches
    for (int i = 0; i < 60; i++) begin
      Rs_addr = REG_ADDR_W'($urandom_range(0, 6));
      Rt_addr = REG_ADDR_W'($urandom_range(0, 6));
      cycle(1'($urandom_range(0, 1)), REG_ADDR_W'($urandom_range(0, 6)),
            $urandom());
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
